sisc_ctrl_mc: RTL and testbench

Parametrised multicycle control unit for the SISC computer. It replaces the fixed five-state controller and keeps the same opcode set and control outputs. It adds four things: a memory-ready handshake with wait states, a bounded memory timeout with a sticky error, a synthesizable HALT state in place of a simulation stop, and a retired-instruction counter. It sits between the instruction register (opcode/mm fields), the status register, and the datapath select/enable lines.

---
 rtl/sisc_ctrl_mc.sv | 181 ++++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_ctrl_mc.sv
// Multicycle control unit for the SISC computer: memory-ready handshake with timeout,
// a HALT state and a retired-instruction counter.
module sisc_ctrl_mc #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned TIMEOUT  = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [3:0]       opcode,
    input  logic [3:0]       mm,
    input  logic [3:0]       stat,
    input  logic             mem_rdy,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             br_sel,
    output logic             pc_rst,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             ir_load,
    output logic             dm_we,
    output logic             dm_re,
    output logic [1:0]       rd_sel,
    output logic [1:0]       alu_op,
    output logic [1:0]       mm_sel,
    output logic [1:0]       swap_reg_sel,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    localparam logic [3:0] OpLod = 4'd1;
    localparam logic [3:0] OpStr = 4'd2;
    localparam logic [3:0] OpSwp = 4'd3;
    localparam logic [3:0] OpBra = 4'd4;
    localparam logic [3:0] OpBrr = 4'd5;
    localparam logic [3:0] OpBne = 4'd6;
    localparam logic [3:0] OpBnr = 4'd7;
    localparam logic [3:0] OpAlu = 4'd8;
    localparam logic [3:0] OpHlt = 4'd15;

    typedef enum logic [2:0] {
        StIllegal   = 3'd0,
        StStart1    = 3'd1,
        StFetch     = 3'd2,
        StDecode    = 3'd3,
        StExecute   = 3'd4,
        StMem       = 3'd5,
        StWriteback = 3'd6,
        StHalt      = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic pos_br, neg_br, is_branch, taken, mem_op, use_wait;

    assign pos_br    = (opcode == OpBra) || (opcode == OpBrr);
    assign neg_br    = (opcode == OpBne) || (opcode == OpBnr);
    assign is_branch = pos_br || neg_br;
    assign taken     = (mm == 4'd0) || (pos_br && |(stat & mm)) || (neg_br && ~|(stat & mm));
    assign mem_op    = (opcode == OpLod) || (opcode == OpStr);
    assign use_wait  = (MEM_WAIT != 0) && mem_op;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q   <= StStart1;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        retired_d = retired_q;
        case (state_q)
            StStart1:    state_d = StFetch;
            StFetch:     state_d = StDecode;
            StDecode:    state_d = (opcode == OpHlt) ? StHalt : StExecute;
            StExecute: begin
                state_d = StMem;
                wait_d  = '0;
            end
            StMem: begin
                // A ready seen in the last allowed cycle still wins over the timeout.
                if (!use_wait || mem_rdy) begin
                    state_d = StWriteback;
                end else if (wait_q == WaitLast) begin
                    state_d   = StHalt;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWriteback: begin
                state_d   = StFetch;
                retired_d = retired_q + CNT_W'(1);
            end
            StHalt:      state_d = StHalt;
            default:     state_d = StStart1;
        endcase
    end

    always_comb begin
        rf_we        = 1'b0;
        wb_sel       = 1'b1;
        br_sel       = 1'b0;
        pc_rst       = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        ir_load      = 1'b0;
        dm_we        = 1'b0;
        dm_re        = 1'b0;
        rd_sel       = 2'b00;
        alu_op       = 2'b10;
        mm_sel       = 2'b00;
        swap_reg_sel = 2'b00;
        case (state_q)
            StStart1: pc_rst = 1'b1;
            StFetch: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            StDecode: begin
                if (is_branch) begin
                    pc_write = taken;
                    pc_sel   = 1'b1;
                    br_sel   = (opcode == OpBra) || (opcode == OpBne);
                end
                if (opcode == OpStr) rd_sel = 2'b01;
            end
            StExecute: begin
                if (opcode == OpAlu) begin
                    alu_op = {1'b0, mm == 4'b1000};
                end else if (mem_op) begin
                    alu_op = mm[3] ? 2'b11 : 2'b10;
                    mm_sel = (mm == 4'd0) ? 2'b01 : 2'b00;
                end else if (opcode == OpSwp) begin
                    alu_op = 2'b11;
                end
            end
            StMem: begin
                if (opcode == OpStr) begin
                    dm_we  = 1'b1;
                    rd_sel = 2'b01;
                end
                if (opcode == OpLod) dm_re = 1'b1;
            end
            StWriteback: begin
                if (opcode == OpAlu) begin
                    rf_we = 1'b1;
                end else if (opcode == OpLod) begin
                    rf_we  = 1'b1;
                    wb_sel = 1'b0;
                end else if (opcode == OpSwp) begin
                    rf_we        = 1'b1;
                    swap_reg_sel = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign halted  = (state_q == StHalt);
    assign mem_err = mem_err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed table-driven bench for sisc_ctrl_mc (MEM_WAIT=1, TIMEOUT=4).
module tb_sisc_ctrl_mc;

    typedef struct packed {
        logic rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, dm_we, dm_re;
        logic [1:0] rd_sel, alu_op, mm_sel, swap_reg_sel;
        logic halted, mem_err;
        logic [15:0] retired;
    } outs_t;

    typedef struct {
        logic [95:0] tag;
        logic [3:0]  op, mm, st;
        logic        rdy;
        outs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_f = 1'b1;
    logic [3:0] opcode = '0, mm = '0, stat = '0;
    logic mem_rdy = 1'b1;
    logic rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, dm_we, dm_re;
    logic [1:0] rd_sel, alu_op, mm_sel, swap_reg_sel;
    logic halted, mem_err;
    logic [15:0] retired;
    outs_t got;

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sisc_ctrl_mc #(.MEM_WAIT(1), .TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
        .rf_we(rf_we), .wb_sel(wb_sel), .br_sel(br_sel), .pc_rst(pc_rst),
        .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load), .dm_we(dm_we),
        .dm_re(dm_re), .rd_sel(rd_sel), .alu_op(alu_op), .mm_sel(mm_sel),
        .swap_reg_sel(swap_reg_sel), .halted(halted), .mem_err(mem_err), .retired(retired)
    );

    assign got = {rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, dm_we, dm_re,
                  rd_sel, alu_op, mm_sel, swap_reg_sel, halted, mem_err, retired};

    function automatic vec_t mk(input logic [95:0] tag, input logic [3:0] op, input logic [3:0] m,
                                input logic [3:0] st, input logic rdy, input logic [15:0] ret);
        vec_t t;
        t.tag = tag;
        t.op = op;
        t.mm = m;
        t.st = st;
        t.rdy = rdy;
        t.exp = '0;
        t.exp.wb_sel = 1'b1;
        t.exp.alu_op = 2'b10;
        t.exp.retired = ret;
        return t;
    endfunction

    function automatic vec_t fetch(input logic [95:0] tag, input logic [3:0] op,
                                   input logic [3:0] m, input logic [3:0] st,
                                   input logic [15:0] ret);
        vec_t t;
        t = mk(tag, op, m, st, 1'b1, ret);
        t.exp.ir_load = 1'b1;
        t.exp.pc_write = 1'b1;
        return t;
    endfunction

    function automatic outs_t rst_exp();
        vec_t t;
        t = mk("reset", 4'd0, 4'd0, 4'd0, 1'b1, 16'd0);
        t.exp.pc_rst = 1'b1;
        return t.exp;
    endfunction

    task automatic check(input logic [95:0] tag, input outs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %0s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            opcode = tbl[i].op;
            mm = tbl[i].mm;
            stat = tbl[i].st;
            mem_rdy = tbl[i].rdy;
            #1;
            check(tbl[i].tag, tbl[i].exp);
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_f = 1'b0;
        #1;
        check("reset", rst_exp());
        @(negedge clk);
        #1;
        check("reset_hold", rst_exp());
        rst_f = 1'b1;
    endtask

    initial begin
        vec_t t;

        // Sequence 1: assorted instructions ending in a memory timeout.
        do_reset();
        tbl.push_back(fetch("alu_f", 8, 8, 0, 0));
        tbl.push_back(mk("alu_d", 8, 8, 0, 1, 0));
        t = mk("alu_e", 8, 8, 0, 1, 0); t.exp.alu_op = 2'b01; tbl.push_back(t);
        tbl.push_back(mk("alu_m", 8, 8, 0, 1, 0));
        t = mk("alu_w", 8, 8, 0, 1, 0); t.exp.rf_we = 1'b1; tbl.push_back(t);

        tbl.push_back(fetch("bne_t_f", 6, 1, 0, 1));
        t = mk("bne_t_d", 6, 1, 0, 1, 1);
        t.exp.pc_write = 1'b1; t.exp.pc_sel = 1'b1; t.exp.br_sel = 1'b1; tbl.push_back(t);
        tbl.push_back(mk("bne_t_e", 6, 1, 0, 1, 1));
        tbl.push_back(mk("bne_t_m", 6, 1, 0, 1, 1));
        tbl.push_back(mk("bne_t_w", 6, 1, 0, 1, 1));

        tbl.push_back(fetch("bne_n_f", 6, 1, 1, 2));
        t = mk("bne_n_d", 6, 1, 1, 1, 2); t.exp.pc_sel = 1'b1; t.exp.br_sel = 1'b1;
        tbl.push_back(t);
        tbl.push_back(mk("bne_n_e", 6, 1, 1, 1, 2));
        tbl.push_back(mk("bne_n_m", 6, 1, 1, 1, 2));
        tbl.push_back(mk("bne_n_w", 6, 1, 1, 1, 2));

        tbl.push_back(fetch("lod_f", 1, 0, 0, 3));
        tbl.push_back(mk("lod_d", 1, 0, 0, 1, 3));
        t = mk("lod_e", 1, 0, 0, 1, 3); t.exp.mm_sel = 2'b01; tbl.push_back(t);
        for (int k = 0; k < 4; k++) begin
            t = mk("lod_m", 1, 0, 0, (k == 3), 3); t.exp.dm_re = 1'b1; tbl.push_back(t);
        end
        t = mk("lod_w", 1, 0, 0, 1, 3); t.exp.rf_we = 1'b1; t.exp.wb_sel = 1'b0;
        tbl.push_back(t);

        tbl.push_back(fetch("brr_f", 5, 0, 0, 4));
        t = mk("brr_d", 5, 0, 0, 1, 4); t.exp.pc_write = 1'b1; t.exp.pc_sel = 1'b1;
        tbl.push_back(t);
        tbl.push_back(mk("brr_e", 5, 0, 0, 1, 4));
        tbl.push_back(mk("brr_m", 5, 0, 0, 1, 4));
        tbl.push_back(mk("brr_w", 5, 0, 0, 1, 4));

        tbl.push_back(fetch("swp_f", 3, 0, 0, 5));
        tbl.push_back(mk("swp_d", 3, 0, 0, 1, 5));
        t = mk("swp_e", 3, 0, 0, 1, 5); t.exp.alu_op = 2'b11; tbl.push_back(t);
        tbl.push_back(mk("swp_m", 3, 0, 0, 1, 5));
        t = mk("swp_w", 3, 0, 0, 1, 5); t.exp.rf_we = 1'b1; t.exp.swap_reg_sel = 2'b10;
        tbl.push_back(t);

        tbl.push_back(fetch("str_f", 2, 8, 0, 6));
        t = mk("str_d", 2, 8, 0, 1, 6); t.exp.rd_sel = 2'b01; tbl.push_back(t);
        t = mk("str_e", 2, 8, 0, 1, 6); t.exp.alu_op = 2'b11; tbl.push_back(t);
        t = mk("str_m", 2, 8, 0, 1, 6); t.exp.dm_we = 1'b1; t.exp.rd_sel = 2'b01;
        tbl.push_back(t);
        tbl.push_back(mk("str_w", 2, 8, 0, 1, 6));

        tbl.push_back(fetch("str_to_f", 2, 0, 0, 7));
        t = mk("str_to_d", 2, 0, 0, 0, 7); t.exp.rd_sel = 2'b01; tbl.push_back(t);
        t = mk("str_to_e", 2, 0, 0, 0, 7); t.exp.mm_sel = 2'b01; tbl.push_back(t);
        for (int k = 0; k < 4; k++) begin
            t = mk("str_to_m", 2, 0, 0, 0, 7); t.exp.dm_we = 1'b1; t.exp.rd_sel = 2'b01;
            tbl.push_back(t);
        end
        for (int k = 0; k < 3; k++) begin
            t = mk("to_halt", 2, 0, 0, (k == 1), 7); t.exp.halted = 1'b1; t.exp.mem_err = 1'b1;
            tbl.push_back(t);
        end
        run_table();

        // Sequence 2: three ALU ops then HLT; reset must also clear mem_err.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(fetch("alu3_f", 8, 0, 0, 16'(k)));
            tbl.push_back(mk("alu3_d", 8, 0, 0, 1, 16'(k)));
            t = mk("alu3_e", 8, 0, 0, 1, 16'(k)); t.exp.alu_op = 2'b00; tbl.push_back(t);
            tbl.push_back(mk("alu3_m", 8, 0, 0, 1, 16'(k)));
            t = mk("alu3_w", 8, 0, 0, 1, 16'(k)); t.exp.rf_we = 1'b1; tbl.push_back(t);
        end
        tbl.push_back(fetch("hlt_f", 15, 0, 0, 3));
        tbl.push_back(mk("hlt_d", 15, 0, 0, 1, 3));
        for (int k = 0; k < 4; k++) begin
            t = mk("hlt_hold", (k == 2) ? 4'd8 : 4'd15, 0, 0, 1, 3); t.exp.halted = 1'b1;
            tbl.push_back(t);
        end
        run_table();

        // Sequence 3: reset lands in the middle of a LOD wait.
        do_reset();
        tbl.push_back(fetch("lodr_f", 1, 8, 0, 0));
        tbl.push_back(mk("lodr_d", 1, 8, 0, 0, 0));
        t = mk("lodr_e", 1, 8, 0, 0, 0); t.exp.alu_op = 2'b11; tbl.push_back(t);
        for (int k = 0; k < 2; k++) begin
            t = mk("lodr_m", 1, 8, 0, 0, 0); t.exp.dm_re = 1'b1; tbl.push_back(t);
        end
        run_table();
        @(negedge clk);
        rst_f = 1'b0;
        #1;
        check("rst_mid", rst_exp());
        @(negedge clk);
        mem_rdy = 1'b1;
        #1;
        check("rst_mid_hold", rst_exp());
        rst_f = 1'b1;
        tbl.push_back(fetch("post_f", 8, 8, 0, 0));
        tbl.push_back(mk("post_d", 8, 8, 0, 1, 0));
        t = mk("post_e", 8, 8, 0, 1, 0); t.exp.alu_op = 2'b01; tbl.push_back(t);
        tbl.push_back(mk("post_m", 8, 8, 0, 1, 0));
        t = mk("post_w", 8, 8, 0, 1, 0); t.exp.rf_we = 1'b1; tbl.push_back(t);
        tbl.push_back(fetch("post_f2", 8, 8, 0, 1));
        run_table();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
